itof_pipe: RTL

ITOF_PIPE -- requirements
Module: itof_pipe

---
 rtl/itof_pipe_if.sv | 23 ++
 rtl/itof_pipe.sv | 88 ++++++++
 2 files changed

// File: rtl/itof_pipe_if.sv
// itof_pipe_if: operand/result bundle between a producer and the int-to-float pipeline.
`default_nettype none

interface itof_pipe_if;
  logic        in_valid;
  logic [31:0] x;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [31:0] y;

  modport master (
    output in_valid, x, stall, flush,
    input  out_valid, y
  );

  modport slave (
    input  in_valid, x, stall, flush,
    output out_valid, y
  );
endinterface

`default_nettype wire

// File: rtl/itof_pipe.sv
// ==========================================================================
// itof_pipe: 3-stage signed int32 -> IEEE-754 single converter,
// round to nearest with ties away from zero, stall/flush control.
// Revision: 1.0
// ==========================================================================
`default_nettype none

module itof_pipe #(
  parameter int LATENCY = 3
) (
  input  wire logic  clk,
  input  wire logic  rstn,
  itof_pipe_if.slave bus
);

  // Valid shift chain: [0]=S1, [1]=S2, [LATENCY-1]=out_valid
  logic [LATENCY-1:0] r_vld;
  logic [31:0]        r_y;

  logic               r_s1_sign;
  logic [31:0]        r_s1_mag;

  logic               r_s2_sign;
  logic [4:0]         r_s2_lzc;
  // [24] leading one (clear only for zero), [23:1] fraction, [0] round bit
  logic [24:0]        r_s2_top;

  logic               w_advance;
  logic [31:0]        w_mag;
  logic [4:0]         w_lzc;
  logic [24:0]        w_norm_top;
  logic [7:0]         w_exp;
  logic [23:0]        w_sum;
  logic [7:0]         w_exp_final;
  logic [31:0]        w_result;

  assign w_advance = !bus.stall && !bus.flush;

  // Two's-complement negate also maps 0x80000000 onto 2^31 as required.
  assign w_mag = bus.x[31] ? (~bus.x + 32'd1) : bus.x;

  always_comb begin
    w_lzc = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_s1_mag[i]) begin
        w_lzc = 5'(31 - i);
      end
    end
  end

  assign w_norm_top = 25'((r_s1_mag << w_lzc) >> 7);

  assign w_exp       = 8'd158 - {3'b000, r_s2_lzc};
  assign w_sum       = {1'b0, r_s2_top[23:1]} + {23'd0, r_s2_top[0]};
  // A carry out of the fraction leaves w_sum[22:0] at zero already.
  assign w_exp_final = w_exp + {7'd0, w_sum[23]};
  assign w_result    = r_s2_top[24] ? {r_s2_sign, w_exp_final, w_sum[22:0]} : 32'h0000_0000;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld <= '0;
      r_y   <= 32'h0000_0000;
    end else if (bus.flush) begin
      r_vld <= '0;
    end else if (!bus.stall) begin
      r_vld <= {r_vld[LATENCY-2:0], bus.in_valid};
      if (r_vld[LATENCY-2]) begin
        r_y <= w_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1_sign <= bus.x[31];
      r_s1_mag  <= w_mag;
      r_s2_sign <= r_s1_sign;
      r_s2_lzc  <= w_lzc;
      r_s2_top  <= w_norm_top;
    end
  end

  assign bus.out_valid = r_vld[LATENCY-1];
  assign bus.y         = r_y;

endmodule

`default_nettype wire
